// File: rtl/capture_pkg.sv
// Shared definitions for the logic-analyzer capture controller: FSM state
// encoding and default capture window geometry.
package capture_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PRETRIG   = 3'd1,
        ST_WAIT_TRIG = 3'd2,
        ST_POSTTRIG  = 3'd3,
        ST_HOLD      = 3'd4
    } state_t;

    localparam int DEF_PRE_SAMPLES      = 160;
    localparam int DEF_SAMPLE_BUFF_SIZE = 640;

endpackage

// File: rtl/capture_controller_if.sv
// Control/status bundle between the capture controller and its environment.
// CAPTURE_AUTO_TRIG_EN adds the auto-trigger timeout input and fired pulse.
interface capture_controller_if #(
    parameter int CHANNEL_COUNT = 10,
    parameter int DIV_WIDTH     = 32
);
    logic                             arm;
    logic                             continuous;
    logic [CHANNEL_COUNT-1:0]         chan_in;
    logic [$clog2(CHANNEL_COUNT)-1:0] trig_chan;
    logic                             trig_rising;
    logic [DIV_WIDTH-1:0]             rate_div;
    logic                             shift;
    logic [CHANNEL_COUNT-1:0]         sample_out;
    logic [2:0]                       state;
    logic                             done;
`ifdef CAPTURE_AUTO_TRIG_EN
    logic [DIV_WIDTH-1:0]             auto_timeout;
    logic                             auto_fired;

    modport master (
        output arm, continuous, chan_in, trig_chan, trig_rising, rate_div, auto_timeout,
        input  shift, sample_out, state, done, auto_fired
    );
    modport slave (
        input  arm, continuous, chan_in, trig_chan, trig_rising, rate_div, auto_timeout,
        output shift, sample_out, state, done, auto_fired
    );
`else
    modport master (
        output arm, continuous, chan_in, trig_chan, trig_rising, rate_div,
        input  shift, sample_out, state, done
    );
    modport slave (
        input  arm, continuous, chan_in, trig_chan, trig_rising, rate_div,
        output shift, sample_out, state, done
    );
`endif
endinterface

// File: rtl/capture_controller_divider.sv
// Free-running sample-rate divider: tick_o is high for the cycle in which the
// count equals rate_div_i, after which the count wraps to zero.
module sample_rate_divider #(
    parameter int DIV_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DIV_WIDTH-1:0] rate_div_i,
    output logic                 tick_o
);
    localparam logic [DIV_WIDTH-1:0] CNT_ZERO = {DIV_WIDTH{1'b0}};
    localparam logic [DIV_WIDTH-1:0] CNT_ONE  = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

    logic [DIV_WIDTH-1:0] cnt_q;
    logic [DIV_WIDTH-1:0] cnt_d;

    // Live compare: a shortened rate_div below the current count falls
    // through to the natural all-ones overflow.
    assign tick_o = (cnt_q == rate_div_i);

    // Next count: wrap on tick, otherwise increment.
    always_comb begin
        cnt_d = cnt_q + CNT_ONE;
        if (tick_o) begin
            cnt_d = CNT_ZERO;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= CNT_ZERO;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/capture_controller.sv
// Capture sequencer: synchronises channels, detects the trigger edge and
// gates SIPO shifting through pre/post-trigger windows. Optional
// CAPTURE_AUTO_TRIG_EN forces a trigger after auto_timeout idle ticks.
module capture_controller
    import capture_pkg::*;
#(
    parameter int CHANNEL_COUNT    = 10,
    parameter int SAMPLE_BUFF_SIZE = DEF_SAMPLE_BUFF_SIZE,
    parameter int PRE_SAMPLES      = DEF_PRE_SAMPLES,
    parameter int DIV_WIDTH        = 32
) (
    input  logic                clk,
    input  logic                reset,
    capture_controller_if.slave bus
);
    localparam int SEL_W = $clog2(CHANNEL_COUNT);
    localparam int CNT_W = $clog2(SAMPLE_BUFF_SIZE + 1);
    localparam logic [CNT_W-1:0] SCNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] SCNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PRE_SAMPLES);
    localparam logic [CNT_W-1:0] POST_LAST = CNT_W'(SAMPLE_BUFF_SIZE - PRE_SAMPLES - 1);
    localparam logic [CHANNEL_COUNT-1:0] CH_ZERO = {CHANNEL_COUNT{1'b0}};

    logic [CHANNEL_COUNT-1:0] sync1_q;
    logic [CHANNEL_COUNT-1:0] sync2_q;
    logic [CHANNEL_COUNT-1:0] sample_q;
    logic                     shift_q;
    logic                     done_q;
    state_t                   state_q;
    state_t                   state_d;
    logic [CNT_W-1:0]         scnt_q;
    logic [CNT_W-1:0]         scnt_d;
    logic [CNT_W-1:0]         scnt_inc_s;
    logic                     tick_s;
    logic                     active_s;
    logic                     cur_s;
    logic                     prev_s;
    logic                     edge_s;
    logic                     fire_s;

    sample_rate_divider #(.DIV_WIDTH(DIV_WIDTH)) u_div (
        .clk        (clk),
        .reset      (reset),
        .rate_div_i (bus.rate_div),
        .tick_o     (tick_s)
    );

    assign scnt_inc_s = scnt_q + SCNT_ONE;
    assign active_s   = (state_q == ST_PRETRIG) || (state_q == ST_WAIT_TRIG) ||
                        (state_q == ST_POSTTRIG);

    // Trigger channel select; sample_q doubles as the edge history since it
    // is reloaded on every tick regardless of state.
    always_comb begin
        cur_s  = 1'b0;
        prev_s = 1'b0;
        for (int i = 0; i < CHANNEL_COUNT; i++) begin
            cur_s  = cur_s  | (sync2_q[i]  & (bus.trig_chan == SEL_W'(i)));
            prev_s = prev_s | (sample_q[i] & (bus.trig_chan == SEL_W'(i)));
        end
        edge_s = bus.trig_rising ? (cur_s & ~prev_s) : (~cur_s & prev_s);
    end

`ifdef CAPTURE_AUTO_TRIG_EN
    localparam logic [DIV_WIDTH-1:0] TCNT_ZERO = {DIV_WIDTH{1'b0}};
    localparam logic [DIV_WIDTH-1:0] TCNT_ONE  = {{(DIV_WIDTH-1){1'b0}}, 1'b1};
    logic [DIV_WIDTH-1:0] tcnt_q;
    logic [DIV_WIDTH-1:0] tcnt_d;
    logic [DIV_WIDTH-1:0] tcnt_inc_s;
    logic                 auto_fired_q;

    assign tcnt_inc_s = tcnt_q + TCNT_ONE;
    assign fire_s = (state_q == ST_WAIT_TRIG) && tick_s && !edge_s &&
                    (bus.auto_timeout != TCNT_ZERO) && (tcnt_inc_s == bus.auto_timeout);
    assign bus.auto_fired = auto_fired_q;

    // Timeout count of edgeless ticks spent in WAIT_TRIG.
    always_comb begin
        tcnt_d = TCNT_ZERO;
        if (state_q != ST_WAIT_TRIG) begin
            tcnt_d = TCNT_ZERO;
        end else if (tick_s) begin
            tcnt_d = tcnt_inc_s;
        end else begin
            tcnt_d = tcnt_q;
        end
    end

    // Timeout counter and fired pulse registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tcnt_q       <= TCNT_ZERO;
            auto_fired_q <= 1'b0;
        end else begin
            tcnt_q       <= tcnt_d;
            auto_fired_q <= fire_s;
        end
    end
`else
    assign fire_s = 1'b0;
`endif

    // FSM next state and sample counter.
    always_comb begin
        state_d = state_q;
        scnt_d  = scnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.arm) begin
                    state_d = ST_PRETRIG;
                    scnt_d  = SCNT_ZERO;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PRETRIG: begin
                if (tick_s) begin
                    scnt_d  = scnt_inc_s;
                    state_d = (scnt_inc_s >= PRE_LAST) ? ST_WAIT_TRIG : ST_PRETRIG;
                end else begin
                    state_d = ST_PRETRIG;
                end
            end
            ST_WAIT_TRIG: begin
                if ((tick_s && edge_s) || fire_s) begin
                    state_d = ST_POSTTRIG;
                    scnt_d  = SCNT_ZERO;
                end else begin
                    state_d = ST_WAIT_TRIG;
                end
            end
            ST_POSTTRIG: begin
                if (tick_s) begin
                    scnt_d  = scnt_inc_s;
                    state_d = (scnt_inc_s >= POST_LAST) ? ST_HOLD : ST_POSTTRIG;
                end else begin
                    state_d = ST_POSTTRIG;
                end
            end
            ST_HOLD: begin
                if (bus.continuous ? tick_s : bus.arm) begin
                    state_d = ST_PRETRIG;
                    scnt_d  = SCNT_ZERO;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_IDLE;
                scnt_d  = SCNT_ZERO;
            end
        endcase
    end

    // Synchroniser, sample/shift outputs and FSM state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q  <= CH_ZERO;
            sync2_q  <= CH_ZERO;
            sample_q <= CH_ZERO;
            shift_q  <= 1'b0;
            done_q   <= 1'b0;
            state_q  <= ST_IDLE;
            scnt_q   <= SCNT_ZERO;
        end else begin
            sync1_q  <= bus.chan_in;
            sync2_q  <= sync1_q;
            sample_q <= tick_s ? sync2_q : sample_q;
            shift_q  <= tick_s & active_s;
            done_q   <= (state_q == ST_HOLD) && (state_d == ST_HOLD);
            state_q  <= state_d;
            scnt_q   <= scnt_d;
        end
    end

    assign bus.shift      = shift_q;
    assign bus.sample_out = sample_q;
    assign bus.state      = state_q;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_capture_controller.sv
// Directed self-checking bench for capture_controller (small 16/4 window).
// With CAPTURE_AUTO_TRIG_EN defined it also exercises the auto-trigger.
module tb_capture_controller;
    import capture_pkg::*;

    localparam int CH  = 10;
    localparam int BUF = 16;
    localparam int PRE = 4;
    localparam int DW  = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    capture_controller_if #(.CHANNEL_COUNT(CH), .DIV_WIDTH(DW)) bus ();

    capture_controller #(
        .CHANNEL_COUNT(CH), .SAMPLE_BUFF_SIZE(BUF), .PRE_SAMPLES(PRE), .DIV_WIDTH(DW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int n_pre, n_wait, n_post, n_other;
    int first_shift, last_shift, done_rise, bad_spacing, exp_spacing;
    bit have_shift;
    logic trig_bit, pre_bit;
    logic [2:0] prev_state;
    logic prev_done;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        n_pre = 0; n_wait = 0; n_post = 0; n_other = 0;
        first_shift = 0; last_shift = 0; done_rise = 0; bad_spacing = 0;
        have_shift = 1'b0; trig_bit = 1'bx; pre_bit = 1'bx;
    endtask

    // One clock; shifts are attributed to the state seen one cycle earlier.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (bus.shift === 1'b1) begin
            case (prev_state)
                3'd1:    begin n_pre++;  pre_bit  = bus.sample_out[3]; end
                3'd2:    begin n_wait++; trig_bit = bus.sample_out[3]; end
                3'd3:    n_post++;
                default: n_other++;
            endcase
            if (have_shift && (cyc - last_shift) != exp_spacing) bad_spacing++;
            if (!have_shift) first_shift = cyc;
            have_shift = 1'b1;
            last_shift = cyc;
        end
        if (bus.done === 1'b1 && prev_done !== 1'b1) done_rise = cyc;
        prev_done  = bus.done;
        prev_state = bus.state;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_state(input logic [2:0] tgt, input int budget, input string tag);
        int n = 0;
        while (bus.state !== tgt && n < budget) begin
            step();
            n++;
        end
        check(tag, bus.state, tgt);
    endtask

    task automatic pulse_arm();
        bus.arm = 1'b1;
        step();
        bus.arm = 1'b0;
    endtask

    initial begin
        int n_idle_bad;
        int hold_n;
        reset = 1'b1;
        bus.arm = 1'b0; bus.continuous = 1'b0; bus.chan_in = 10'd0;
        bus.trig_chan = 4'd3; bus.trig_rising = 1'b1; bus.rate_div = 32'd0;
`ifdef CAPTURE_AUTO_TRIG_EN
        bus.auto_timeout = 32'd0;
`endif
        exp_spacing = 1;
        clear_counts();
        prev_state = 3'd0; prev_done = 1'b0;
        steps(3);
        check("rst_state", bus.state, 32'd0);
        check("rst_shift", bus.shift, 32'd0);
        check("rst_done", bus.done, 32'd0);
        check("rst_sample", bus.sample_out, 32'd0);
        reset = 1'b0;

        // Free run without arming; also sync latency of sample_out.
        bus.chan_in = 10'h2A5;
        steps(2);
        check("sync_lat_2", bus.sample_out, 32'd0);
        step();
        check("sync_lat_3", bus.sample_out, 32'h2A5);
        n_idle_bad = 0;
        for (int i = 0; i < 1000; i++) begin
            bus.chan_in = 10'(i * 37);
            step();
            if (bus.state !== 3'd0) n_idle_bad++;
        end
        check("free_shifts", n_pre + n_wait + n_post + n_other, 32'd0);
        check("free_idle", n_idle_bad, 32'd0);

        // Rising edge on channel 3 presented at the first WAIT_TRIG tick.
        bus.chan_in = 10'd0;
        steps(5);
        clear_counts();
        pulse_arm();
        steps(2);
        bus.chan_in = 10'h008;
        wait_state(3'd4, 60, "rise_hold");
        steps(20);
        check("rise_pre", n_pre, 32'd4);
        check("rise_wait", n_wait, 32'd1);
        check("rise_post", n_post, 32'd11);
        check("rise_total", n_pre + n_wait + n_post + n_other, 32'd16);
        check("rise_trig_bit", trig_bit, 32'd1);
        check("rise_pre_bit", pre_bit, 32'd0);
        check("rise_done_lat", done_rise - last_shift, 32'd1);
        check("rise_done", bus.done, 32'd1);
        check("rise_still_hold", bus.state, 32'd4);

        // Falling trigger on channel 2; edges on channel 5 and a rising edge on 2 are ignored.
        bus.chan_in = 10'd0; bus.trig_chan = 4'd2; bus.trig_rising = 1'b0;
        steps(5);
        clear_counts();
        pulse_arm();
        wait_state(3'd2, 20, "fall_wait_enter");
        for (int i = 0; i < 40; i++) begin
            if (i % 3 == 0) bus.chan_in[5] = ~bus.chan_in[5];
            step();
        end
        bus.chan_in[2] = 1'b1;
        steps(10);
        check("fall_wrong_chan", bus.state, 32'd2);
        check("fall_no_post", n_post, 32'd0);
        bus.chan_in[2] = 1'b0;
        steps(2);
        check("fall_lat_2", bus.state, 32'd2);
        step();
        check("fall_lat_3", bus.state, 32'd3);
        wait_state(3'd4, 40, "fall_hold");
        check("fall_post", n_post, 32'd11);

        // Rate divider of 9: shifts exactly ten cycles apart.
        bus.chan_in = 10'd0; bus.trig_chan = 4'd3; bus.trig_rising = 1'b1; bus.rate_div = 32'd9;
        steps(30);
        clear_counts();
        exp_spacing = 10;
        pulse_arm();
        wait_state(3'd2, 100, "div_wait_enter");
        bus.chan_in[3] = 1'b1;
        wait_state(3'd4, 300, "div_hold");
        steps(3);
        check("div_total", n_pre + n_wait + n_post + n_other, 32'd16);
        check("div_spacing", bad_spacing, 32'd0);
        check("div_span", last_shift - first_shift, 32'd150);
        check("div_done_lat", done_rise - last_shift, 32'd1);

        // Continuous: HOLD lasts exactly one tick period before PRETRIG.
        bus.continuous = 1'b1;
        wait_state(3'd1, 30, "cont_rearm");
        check("cont_done_low", bus.done, 32'd0);
        wait_state(3'd2, 100, "cont_wait");
        bus.chan_in[3] = 1'b0;
        steps(12);
        check("cont_fall_ignored", bus.state, 32'd2);
        bus.chan_in[3] = 1'b1;
        wait_state(3'd4, 200, "cont_hold");
        hold_n = 1;
        for (int i = 0; i < 50; i++) begin
            step();
            if (bus.state !== 3'd4) break;
            hold_n++;
        end
        check("cont_hold_len", hold_n, 32'd10);
        check("cont_pretrig", bus.state, 32'd1);

        // Reset in POSTTRIG aborts to IDLE immediately.
        wait_state(3'd2, 100, "rst_wait");
        bus.chan_in[3] = 1'b0;
        steps(12);
        bus.chan_in[3] = 1'b1;
        wait_state(3'd3, 30, "rst_post");
        steps(3);
        reset = 1'b1;
        bus.rate_div = 32'd0;
        #1;
        check("rst_mid_state", bus.state, 32'd0);
        check("rst_mid_shift", bus.shift, 32'd0);
        check("rst_mid_done", bus.done, 32'd0);
        steps(2);
        bus.continuous = 1'b0;
        reset = 1'b0;
        clear_counts();
        exp_spacing = 1;
        steps(20);
        check("rst_after_idle", bus.state, 32'd0);
        check("rst_after_shifts", n_pre + n_wait + n_post + n_other, 32'd0);

`ifdef CAPTURE_AUTO_TRIG_EN
        // Auto-trigger after 50 edgeless ticks in WAIT_TRIG.
        bus.auto_timeout = 32'd50;
        clear_counts();
        pulse_arm();
        wait_state(3'd2, 20, "auto_wait_enter");
        hold_n = 1;
        for (int i = 0; i < 200; i++) begin
            step();
            if (bus.state !== 3'd2) break;
            hold_n++;
        end
        check("auto_wait_len", hold_n, 32'd50);
        check("auto_fired", bus.auto_fired, 32'd1);
        check("auto_post_state", bus.state, 32'd3);
        step();
        check("auto_fired_pulse", bus.auto_fired, 32'd0);
        wait_state(3'd4, 40, "auto_hold");
        check("auto_post", n_post, 32'd11);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
